spi_ram_master: RTL and testbench
=================================

# spi_ram_master

Bit-level SPI master for the external serial SRAM. It sits directly downstream of the OBI-to-SPI RAM shim. Each accepted word command (address, write data, direction) becomes one chip-select-framed SPI mode-0 transaction: opcode, address, then 4 data bytes. A one-cycle response carries read data back to the shim.

## Interface
- `AddrBits`, default 24: address bits sent on the wire; legal values are 16 or 24.
- `CmdRead`, default 8'h03: read opcode.
- `CmdWrite`, default 8'h02: write opcode.
- `clk_i`, in, 1: single clock; all logic on its rising edge.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `cmd_valid_i`, in, 1: command offered.
- `cmd_ready_o`, out, 1: high only in IDLE; a command is accepted when valid and ready are both high.
- `cmd_we_i`, in, 1: 1 = write, 0 = read.
- `cmd_addr_i`, in, 32: byte address; only bits [AddrBits-1:0] are sent.
- `cmd_wdata_i`, in, 32: write word.
- `clk_div_hi_i`, in, 5: SCK high phase lasts this value + 1 cycles.
- `clk_div_lo_i`, in, 5: SCK low phase lasts this value + 1 cycles.
- `rsp_valid_o`, out, 1: one-cycle pulse when the transaction ends.
- `rsp_rdata_o`, out, 32: read word; 0 after a write; held until the next response.
- `spi_cs_n_o`, out, 1: chip select, active-low.
- `spi_sck_o`, out, 1: serial clock, CPOL=0.
- `spi_mosi_o`, out, 1: serial data out.
- `spi_miso_i`, in, 1: serial data in.

## Operation
- States:
  - IDLE: accept a command, go to SHIFT.
  - SHIFT: run until the bit counter reaches N, go to HOLD.
  - HOLD: lasts 1 cycle, go to DONE.
  - DONE: lasts 1 cycle, go to IDLE.
- On acceptance the block latches `we`, the address, the write data and both divider values. Divider changes during a transaction are ignored.
- Bit count N = 8 + AddrBits + 32, giving 64 at the default.
- Shift order:
  - Opcode first, MSB first.
  - Address next, MSB first.
  - Data last, byte 0 first (bits [7:0]), then bytes 1, 2, 3; each byte MSB first.
- Received data bytes are assembled the same way, so the first received byte lands in [7:0].
- Mode 0 timing:
  - MOSI updates at the start of each low phase.
  - MISO is sampled on the clock edge that raises SCK.
  - MISO is ignored during the opcode and address phases.
- Bit period P = clk_div_lo + clk_div_hi + 2 cycles.
- Reset values: state IDLE, `spi_cs_n_o`=1, `spi_sck_o`=0, `spi_mosi_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0, counters 0. `cmd_ready_o` is 1 from the first cycle after reset.
- Reset mid-transaction: on the next cycle `cs_n`=1 and `sck`=0. No response is issued and the command is lost.
- `cmd_valid_i` is ignored outside IDLE. No queueing.

## Timing
- Acceptance happens in cycle T0.
- T0+1: `cs_n` falls, `sck` is low, MOSI carries the first opcode bit.
- Bit k (k = 0..N-1) occupies cycles T0+1+k·P through T0+(k+1)·P: first the low phase, then the high phase.
- HOLD at T0+N·P+1: `cs_n` low, `sck` low.
- T0+N·P+2: `cs_n` high, `rsp_valid_o`=1, `rsp_rdata_o` valid (state DONE).
- T0+N·P+3: IDLE with `cmd_ready_o`=1. The earliest next acceptance leaves `cs_n` high for at least 2 cycles.
- Latency from acceptance to response is 2+N·P cycles: 130 at default with dividers at 0/0.

## Configuration
- `SPI_RAM_MASTER_FAST_READ_EN` defined:
  - Reads use opcode 8'h0B.
  - 8 dummy bits (MOSI=0, MISO ignored) are inserted between address and data.
  - Read N = AddrBits + 48.
  - Writes are unchanged.
- Not defined: reads use `CmdRead` with no dummy bits.

## Structure
- Package `spi_ram_pkg` holds:
  - the state enum;
  - opcode constants (READ 8'h03, WRITE 8'h02, FAST_READ 8'h0B);
  - the dummy-bit count;
  - the divider width (5).
- Sub-module `spi_ram_sck_gen`: phase counter that produces `sck` and single-cycle `rise`/`fall` ticks from the latched dividers. It is enabled only in SHIFT.

## Test plan
- Write 32'hDEADBEEF to address 0x000104 with dividers 0/0 → MOSI bytes 02 00 01 04 EF BE AD DE; `rsp_valid_o` at T0+130; `rsp_rdata_o`=0.
- Read address 0x000010 with the MISO model returning 11 22 33 44 → MOSI 03 00 00 10; `rsp_rdata_o`=32'h44332211 at T0+130.
- Dividers hi=2, lo=3 → SCK high for 3 cycles, low for 4; response at T0+450. Changing the dividers to 0/0 mid-transfer has no effect.
- `cmd_valid_i` held high back-to-back → `cmd_ready_o` is low during the transaction; the second command is accepted at T0+131; `cs_n` is high for 2 cycles between frames.
- `rst_ni` low at T0+40 of a read → next cycle `cs_n`=1, `sck`=0, no `rsp_valid_o`; a subsequent write completes normally.
- FAST_READ_EN, read 0x000020 → MOSI 0B 00 00 20 00; response at T0+146; a write still finishes at T0+130.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared state type, opcodes and sizing constants for the serial SRAM master.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold,
    StDone
  } state_e;

  localparam logic [7:0] OpRead     = 8'h03;
  localparam logic [7:0] OpWrite    = 8'h02;
  localparam logic [7:0] OpFastRead = 8'h0B;

  localparam int unsigned DummyBits = 8;
  localparam int unsigned DivW      = 5;
  // Wide enough for the longest frame: 8 + 24 + 8 + 32 = 72 bits.
  localparam int unsigned BitCntW   = 7;

  // Reorders a word so byte 0 sits in the top byte (first on the wire).
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_ram_sck_gen.sv
// SPI clock generator: CPOL=0 phase counter with single-cycle rise/fall ticks.
// The ticks are asserted in the cycle whose closing edge changes sck.
module spi_ram_sck_gen
  import spi_ram_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [DivW-1:0] div_hi_i,
  input  logic [DivW-1:0] div_lo_i,
  output logic            sck_o,
  output logic            rise_o,
  output logic            fall_o
);

  logic [DivW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;

  // Phase counting and tick decode; idles with sck low and counter cleared.
  always_comb begin
    rise_o = en_i && !sck_q && (cnt_q == div_lo_i);
    fall_o = en_i && sck_q && (cnt_q == div_hi_i);
    cnt_d  = '0;
    sck_d  = 1'b0;
    if (en_i) begin
      if (rise_o || fall_o) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sck_d = sck_q;
      end
    end
  end

  // Phase state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_ram_master.sv
// Bit-level SPI mode-0 master for the external serial SRAM: one framed
// transaction (opcode, address, 4 data bytes) per accepted word command.
// Optional build macro SPI_RAM_MASTER_FAST_READ_EN: reads use opcode 0x0B
// with 8 dummy bits between address and data.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned AddrBits = 24,
  parameter logic [7:0]  CmdRead  = OpRead,
  parameter logic [7:0]  CmdWrite = OpWrite
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [31:0]     cmd_addr_i,
  input  logic [31:0]     cmd_wdata_i,
  input  logic [DivW-1:0] clk_div_hi_i,
  input  logic [DivW-1:0] clk_div_lo_i,
  output logic            rsp_valid_o,
  output logic [31:0]     rsp_rdata_o,
  output logic            spi_cs_n_o,
  output logic            spi_sck_o,
  output logic            spi_mosi_o,
  input  logic            spi_miso_i
);

`ifdef SPI_RAM_MASTER_FAST_READ_EN
  localparam int unsigned RdDummy = DummyBits;
  localparam logic [7:0]  RdOp    = OpFastRead;
  logic [7:0] unused_cmd_read;
  assign unused_cmd_read = CmdRead;
`else
  localparam int unsigned RdDummy = 0;
  localparam logic [7:0]  RdOp    = CmdRead;
`endif

  // Frame register is sized for the longest frame; shorter frames are left-aligned.
  localparam int unsigned        FrameW      = 8 + AddrBits + RdDummy + 32;
  localparam logic [BitCntW-1:0] LastWr      = BitCntW'(8 + AddrBits + 32 - 1);
  localparam logic [BitCntW-1:0] LastRd      = BitCntW'(8 + AddrBits + RdDummy + 32 - 1);
  localparam logic [BitCntW-1:0] RdDataStart = BitCntW'(8 + AddrBits + RdDummy);

  state_e               state_q, state_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FrameW-1:0]    sr_q, sr_d, frame;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 we_q, we_d;
  logic [DivW-1:0]      div_hi_q, div_hi_d, div_lo_q, div_lo_d;
  logic [31:0]          rx_q, rx_d, rdata_q, rdata_d;
  logic                 sck_rise, sck_fall;
  logic [BitCntW-1:0]   bit_last;

  logic [31-AddrBits:0] unused_addr_hi;
  assign unused_addr_hi = cmd_addr_i[31:AddrBits];

  // Outgoing frame built from the offered command.
  always_comb begin
    if (cmd_we_i) begin
      frame = FrameW'({CmdWrite, cmd_addr_i[AddrBits-1:0], byte_swap(cmd_wdata_i)}) << RdDummy;
    end else begin
      frame = FrameW'({RdOp, cmd_addr_i[AddrBits-1:0]}) << (RdDummy + 32);
    end
  end

  assign bit_last = we_q ? LastWr : LastRd;

  spi_ram_sck_gen u_sck_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (state_q == StShift),
    .div_hi_i (div_hi_q),
    .div_lo_i (div_lo_q),
    .sck_o    (spi_sck_o),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall)
  );

  // Transaction sequencing, bit shifting and response capture.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    mosi_d    = mosi_q;
    we_d      = we_q;
    div_hi_d  = div_hi_q;
    div_lo_d  = div_lo_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          mosi_d    = frame[FrameW-1];
          sr_d      = frame << 1;
          we_d      = cmd_we_i;
          div_hi_d  = clk_div_hi_i;
          div_lo_d  = clk_div_lo_i;
        end
      end
      StShift: begin
        if (sck_rise && !we_q && (bit_cnt_q >= RdDataStart)) begin
          rx_d = {rx_q[30:0], spi_miso_i};
        end
        if (sck_fall) begin
          if (bit_cnt_q == bit_last) begin
            state_d = StHold;
            mosi_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            mosi_d    = sr_q[FrameW-1];
            sr_d      = sr_q << 1;
          end
        end
      end
      StHold: begin
        state_d = StDone;
        rdata_d = we_q ? 32'h0 : byte_swap(rx_q);
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    cs_n_d = !((state_d == StShift) || (state_d == StHold));
  end

  // Sequential state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      we_q      <= 1'b0;
      div_hi_q  <= '0;
      div_lo_q  <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      we_q      <= we_d;
      div_hi_q  <= div_hi_d;
      div_lo_q  <= div_lo_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StDone);
  assign rsp_rdata_o = rdata_q;
  assign spi_cs_n_o  = cs_n_q;
  assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: SPI SRAM slave model, reference
// memory and a response scoreboard. Honours SPI_RAM_MASTER_FAST_READ_EN.
module tb_spi_ram_master;

  localparam int AB = 24;
`ifdef SPI_RAM_MASTER_FAST_READ_EN
  localparam int         DUM   = 8;
  localparam logic [7:0] RD_OP = 8'h0B;
`else
  localparam int         DUM   = 0;
  localparam logic [7:0] RD_OP = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [4:0]  div_hi = '0, div_lo = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        cs_n, sck, mosi, miso = 1'b0;

  always #5 clk = ~clk;

  spi_ram_master dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .clk_div_hi_i (div_hi),
    .clk_div_lo_i (div_lo),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .spi_cs_n_o   (cs_n),
    .spi_sck_o    (sck),
    .spi_mosi_o   (mosi),
    .spi_miso_i   (miso)
  );

  typedef struct {
    logic [71:0] frame;
    int          cmp;
    int          nbits;
    logic [31:0] rdata;
    int          t_rsp;
    int          hi;
    int          lo;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem   [1024];
  logic [7:0]  slave_mem [1024];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          last_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: expected wire frame, response data and response cycle.
  task automatic push_exp(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int hi, input int lo, input int t0);
    exp_t       e;
    logic [9:0] ix;
    e.nbits = we ? 40 + AB : 40 + AB + DUM;
    e.cmp   = we ? e.nbits : 8 + AB + DUM;
    e.frame = {(we ? 8'h02 : RD_OP), addr[23:0], 40'h0};
    e.rdata = '0;
    for (int i = 0; i < 4; i++) begin
      ix = addr[9:0] + 10'(i);
      if (we) begin
        e.frame[39-8*i -: 8] = wd[8*i +: 8];
        ref_mem[ix] = wd[8*i +: 8];
      end else begin
        e.rdata[8*i +: 8] = ref_mem[ix];
      end
    end
    e.hi    = hi;
    e.lo    = lo;
    e.t_rsp = t0 + 2 + e.nbits * (hi + lo + 2);
    sb.push_back(e);
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input int hi, input int lo, input bit keep, output int t0);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    div_hi    = 5'(hi);
    div_lo    = 5'(lo);
    t0        = cyc;
    push_exp(we, addr, wd, hi, lo, t0);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || !cmd_ready) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", 72'(guard < 5000), 1);
  endtask

  // SPI slave model plus response monitor, evaluated away from the active edge.
  logic        sck_prev = 1'b0, in_frame = 1'b0;
  int          nb = 0, done_nb = 0, lo_run = 0, hi_run = 0, phase_err = 0, cs_hi_run = 0;
  logic [71:0] rx_frame = '0, done_frame = '0;
  logic [7:0]  s_op = '0;
  logic [23:0] s_addr = '0;

  always @(negedge clk) begin
    int          dstart, j;
    exp_t        e;
    logic [71:0] mask;
    if (!rst_n) begin
      in_frame = 1'b0;
      sck_prev = 1'b0;
    end else begin
      if (cs_n) begin
        if (in_frame) begin
          done_frame = rx_frame;
          done_nb    = nb;
          if (s_op == 8'h02 && nb >= 40 + AB) begin
            for (int i = 0; i < 4; i++) slave_mem[s_addr[9:0] + 10'(i)] = rx_frame[39-8*i -: 8];
          end
          in_frame = 1'b0;
        end
        cs_hi_run++;
      end else begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          nb        = 0;
          rx_frame  = '0;
          lo_run    = 0;
          hi_run    = 0;
          phase_err = 0;
          last_gap  = cs_hi_run;
          cs_hi_run = 0;
          miso      = 1'($urandom);
        end
        if (sck) begin
          if (!sck_prev) begin
            if (sb.size() != 0 && lo_run != sb[0].lo + 1) phase_err++;
            if (nb < 72) rx_frame[71-nb] = mosi;
            nb++;
            hi_run = 0;
            if (nb == 8) s_op = rx_frame[71:64];
            if (nb == 8 + AB) s_addr = rx_frame[63 -: 24];
          end
          hi_run++;
        end else begin
          if (sck_prev) begin
            if (sb.size() != 0 && hi_run != sb[0].hi + 1) phase_err++;
            lo_run = 0;
            dstart = (s_op == 8'h0B) ? 16 + AB : 8 + AB;
            if (nb >= dstart && nb < dstart + 32) begin
              j    = nb - dstart;
              miso = slave_mem[s_addr[9:0] + 10'(j / 8)][7 - (j % 8)];
            end else begin
              miso = 1'($urandom);
            end
          end
          lo_run++;
        end
      end
      sck_prev = sck;

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e    = sb.pop_front();
          mask = ~72'h0 << (72 - e.cmp);
          check("rsp_time", cyc, e.t_rsp);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("frame_len", done_nb, e.nbits);
          check("frame_bits", done_frame & mask, e.frame & mask);
          check("sck_phase", phase_err, 0);
          check("cs_n_in_done", cs_n, 1);
        end
      end
    end
  end

  initial begin
    int t0, t1;
    logic [31:0] r;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = 8'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
    for (int i = 16; i < 20; i++) slave_mem[i] = ref_mem[i];

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // Directed write and reads.
    issue(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 1'b0, t0);
    wait_idle();
    check("wr_on_wire", {slave_mem[263], slave_mem[262], slave_mem[261], slave_mem[260]},
          32'hDEAD_BEEF);
    check("wr_rdata_zero", rsp_rdata, 0);
    issue(1'b0, 32'h0000_0010, 32'h0, 0, 0, 1'b0, t0);
    wait_idle();
    check("rd_rdata_held", rsp_rdata, 32'h4433_2211);
    issue(1'b0, 32'h0000_0020, 32'h0, 0, 0, 1'b0, t0);
    wait_idle();

    // Slow dividers, changed mid-transfer.
    issue(1'b1, 32'h0000_0200, 32'h0BAD_CAFE, 2, 3, 1'b0, t0);
    repeat (100) @(negedge clk);
    div_hi = '0;
    div_lo = '0;
    wait_idle();

    // Back-to-back commands with valid held high.
    issue(1'b1, 32'h0000_0300, 32'h1234_5678, 0, 0, 1'b1, t0);
    check("busy_ready", cmd_ready, 0);
    issue(1'b1, 32'h0000_0304, 32'h9ABC_DEF0, 0, 0, 1'b0, t1);
    check("b2b_accept", t1 - t0, 131);
    repeat (4) @(negedge clk);
    check("b2b_cs_gap", last_gap, 2);
    wait_idle();

    // Reset in the middle of a read.
    issue(1'b0, 32'h0000_0040, 32'h0, 0, 0, 1'b0, t0);
    while (cyc < t0 + 40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sck", sck, 0);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    repeat (150) @(negedge clk);
    issue(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 0, 0, 1'b0, t0);
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 24; n++) begin
      r = $urandom;
      issue(1'($urandom), r, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, t0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
